serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// and presents the difference and final borrow with a one-cycle done pulse.
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             diff_bit;
  logic             borrow_next;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    br_d        = br_q;
    cnt_d       = cnt_q;
    d_d         = d_q;
    bout_d      = bout_q;
    diff_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    borrow_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d             = a_sh_q >> 1;
        b_sh_d             = b_sh_q >> 1;
        res_d              = res_q >> 1;
        res_d[WIDTH-1]     = diff_bit;
        br_d               = borrow_next;
        // The last bit lands in the result on the same edge the outputs load,
        // so the outputs take the next-state value of the result and borrow.
        if (cnt_q == LAST) begin
          state_d = DONE;
          d_d     = res_d;
          bout_d  = borrow_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, operand
// changes mid-run, reset abort, exhaustive 4-bit sweep and random operands.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] d;
  logic         bout;
  logic         busy;
  logic         done;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] last_d;
  logic         last_bout;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: difference is a - b wrapped to W bits, borrow when a < b.
  task automatic model(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       output logic [W-1:0] ed, output logic eb);
    int df;
    df = int'(op_a) - int'(op_b);
    ed = W'(df);
    eb = (op_a < op_b);
  endtask

  // Called just after an edge with the DUT idle; leaves the DUT idle again.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    int           k;
    logic [W-1:0] ed;
    logic         eb;
    model(op_a, op_b, ed, eb);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    chk("busy_accept", 32'(busy), 32'(1'b1));
    chk("done_early", 32'(done), 32'(1'b0));
    k = 0;
    while (k < 20) begin
      step();
      k++;
      if (done === 1'b1) break;
      chk("busy_run", 32'(busy), 32'(1'b1));
      chk("hold_run", 32'({bout, d}), 32'({last_bout, last_d}));
    end
    chk("latency", 32'(k), 32'(W));
    chk("d", 32'(d), 32'(ed));
    chk("bout", 32'(bout), 32'(eb));
    chk("busy_done", 32'(busy), 32'(1'b1));
    $display("op a=%0d b=%0d -> d=%0d bout=%0d (model d=%0d bout=%0d) latency=%0d",
             op_a, op_b, d, bout, ed, eb, k);
    last_d    = ed;
    last_bout = eb;
    step();
    chk("done_pulse", 32'(done), 32'(1'b0));
    chk("busy_idle", 32'(busy), 32'(1'b0));
  endtask

  initial begin
    int           k;
    logic [W-1:0] ed;
    logic         eb;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    last_d    = '0;
    last_bout = 1'b0;
    repeat (3) step();
    chk("rst_d", 32'(d), 32'(0));
    chk("rst_bout", 32'(bout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    $display("reset applied");
    rst = 1'b0;

    // Directed corner cases
    run_op(4'd9, 4'd5);
    run_op(4'd5, 4'd9);
    run_op(4'd0, 4'd1);
    run_op(4'd0, 4'd0);
    run_op(4'd15, 4'd15);
    run_op(4'd15, 4'd0);
    run_op(4'd7, 4'd2);

    // Idle with start low holds the last result while inputs wander
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      step();
      chk("idle_hold", 32'({bout, d}), 32'({last_bout, last_d}));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_done", 32'(done), 32'(0));
    end
    $display("idle hold d=%0d bout=%0d", d, bout);

    // start held high; operands change after acceptance
    a = 4'd9;
    b = 4'd5;
    start = 1'b1;
    step();
    a = 4'd2;
    b = 4'd7;
    k = 0;
    while (k < 20) begin
      step();
      k++;
      if (done === 1'b1) break;
    end
    chk("held_latency1", 32'(k), 32'(W));
    chk("held_d1", 32'(d), 32'(4));
    chk("held_bout1", 32'(bout), 32'(0));
    $display("held start first d=%0d bout=%0d", d, bout);
    k = 0;
    while (k < 30) begin
      step();
      k++;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    model(4'd2, 4'd7, ed, eb);
    chk("held_gap", 32'(k), 32'(W + 2));
    chk("held_d2", 32'(d), 32'(ed));
    chk("held_bout2", 32'(bout), 32'(eb));
    $display("held start second d=%0d bout=%0d gap=%0d", d, bout, k);
    last_d    = ed;
    last_bout = eb;
    step();
    chk("held_done_end", 32'(done), 32'(0));

    // Reset in the second RUN cycle aborts the operation
    a = 4'd9;
    b = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_d", 32'(d), 32'(0));
    chk("abort_bout", 32'(bout), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    $display("reset during run d=%0d bout=%0d busy=%0d", d, bout, busy);
    last_d    = '0;
    last_bout = 1'b0;
    rst = 1'b0;
    run_op(4'd3, 4'd1);

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(W'(i), W'(j));
      end
    end

    // Random operands
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
